// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/decode constants: FSM state codes, opcode field geometry and
// the opcodes the control unit also recognises.
package instr_fetch_unit_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;

endpackage

// File: rtl/instr_fetch_unit_pc_register.sv
// Program counter: reset load, sequential step and step-aligned branch load.
module pc_register #(
  parameter int                ADDR_W   = 32,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_seq,
  input  logic              load_br,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] STEP_MASK = ADDR_W'(PC_STEP - 1);

  logic [ADDR_W-1:0] r_pc;

  // Branch targets are forced onto an instruction boundary; the step wraps mod 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (load_br) begin
      r_pc <= target & ~STEP_MASK;
    end else if (load_seq) begin
      r_pc <= r_pc + STEP;
    end else begin
      r_pc <= r_pc;
    end
  end

  assign pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: req/ack fetch from instruction memory, an
// instruction register with valid/ready hand-off to decode, and halt handling.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [OP_W-1:0]   HALT_OP  = OP_HALT
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [OP_W-1:0]    op,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  logic [1:0]         r_state;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic               r_halted;
  logic [15:0]        r_count;

  logic              w_consume;
  logic              w_halt_op;
  logic              w_load_seq;
  logic              w_load_br;
  logic [ADDR_W-1:0] w_pc;

  assign w_consume  = (r_state == S_HOLD) & r_valid & instr_ready;
  assign w_halt_op  = (r_instr[INSTR_W-1 -: OP_W] == HALT_OP);
  // A halting opcode overrides any simultaneous branch request.
  assign w_load_br  = w_consume & ~w_halt_op & branch_en;
  assign w_load_seq = w_consume & ~w_halt_op & ~branch_en;

  pc_register #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk      (clk),
    .rst      (rst),
    .load_seq (w_load_seq),
    .load_br  (w_load_br),
    .target   (branch_target),
    .pc       (w_pc)
  );

  // Fetch FSM, instruction register and saturating consume counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_count  <= 16'd0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_consume) begin
            r_valid <= 1'b0;
            if (r_count != 16'hFFFF) begin
              r_count <= r_count + 16'd1;
            end
            if (w_halt_op) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_HALT: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: begin
          r_state <= S_REQ;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = w_pc;
  assign pc          = w_pc;
  assign instr       = r_instr;
  assign op          = r_instr[INSTR_W-1 -: OP_W];
  assign instr_valid = r_valid;
  assign halted      = r_halted;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic        use_table;
  logic [31:0] rnd_rdata;

  // second instance near the top of the address space, always acking and consuming
  logic        w_req2;
  logic [31:0] w_addr2;
  logic [31:0] w_instr2;
  logic [5:0]  w_op2;
  logic        w_valid2;
  logic [31:0] w_pc2;
  logic        w_halted2;
  logic [15:0] w_count2;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  assign imem_rdata = use_table ? {6'b000000, imem_addr[27:2]} : rnd_rdata;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .op(op),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .branch_en(branch_en),
    .branch_target(branch_target), .pc(pc), .halted(halted), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req2), .imem_addr(w_addr2),
    .imem_ack(1'b1), .imem_rdata(32'h0000_0000), .instr(w_instr2), .op(w_op2),
    .instr_valid(w_valid2), .instr_ready(1'b1), .branch_en(1'b0),
    .branch_target(32'h0000_0000), .pc(w_pc2), .halted(w_halted2), .fetch_count(w_count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction-level model: is an instruction waiting, where is the next fetch, has HALT been taken.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_have;
  logic        m_halted;
  logic [15:0] m_count;

  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0; m_instr <= 32'h0; m_have <= 1'b0; m_halted <= 1'b0; m_count <= 16'd0;
    end else if (m_halted) begin
      m_have <= 1'b0;
    end else if (!m_have) begin
      if (imem_ack) begin
        m_instr <= imem_rdata;
        m_have  <= 1'b1;
      end
    end else if (instr_ready) begin
      m_have  <= 1'b0;
      m_count <= (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
      if (m_instr[31:26] == 6'h3F) m_halted <= 1'b1;
      else if (branch_en) m_pc <= {branch_target[31:2], 2'b00};
      else m_pc <= m_pc + 32'd4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("req",    {63'd0, imem_req},    {63'd0, !m_halted && !m_have});
      check("addr",   {32'd0, imem_addr},   {32'd0, m_pc});
      check("pc",     {32'd0, pc},          {32'd0, m_pc});
      check("valid",  {63'd0, instr_valid}, {63'd0, m_have});
      check("instr",  {32'd0, instr},       {32'd0, m_instr});
      check("op",     {58'd0, op},          {58'd0, m_instr[31:26]});
      check("halted", {63'd0, halted},      {63'd0, m_halted});
      check("count",  {48'd0, fetch_count}, {48'd0, m_count});
    end
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; branch_en = 1'b0;
    branch_target = 32'h0; use_table = 1'b1; rnd_rdata = 32'h0;
    @(negedge clk);
    chk_en = 1'b1;
    check("lit_rst_valid", {63'd0, instr_valid}, 64'd0);
    check("lit_rst_count", {48'd0, fetch_count}, 64'd0);
    check("lit_rst_pc",    {32'd0, pc},          64'd0);
    check("lit_rst_req",   {63'd0, imem_req},    64'd1);
    @(negedge clk);

    // back-to-back fetch: request every other cycle, word k at address 4k
    rst = 1'b0; imem_ack = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        check("lit_seq_req",  {63'd0, imem_req},  64'd1);
        check("lit_seq_addr", {32'd0, imem_addr}, 64'(4 * (i / 2)));
      end else begin
        check("lit_seq_valid", {63'd0, instr_valid}, 64'd1);
        check("lit_seq_instr", {32'd0, instr},       64'(i / 2));
        check("lit_seq_op",    {58'd0, op},          64'd0);
      end
      if (i == 0) check("lit_wrap_first", {32'd0, w_addr2}, 64'hFFFF_FFFC);
      if (i == 2) check("lit_wrap_next",  {31'd0, w_req2, w_addr2}, 64'h1_0000_0000);
      @(negedge clk);
    end
    check("lit_seq_count", {48'd0, fetch_count}, 64'd4);

    // memory stall then decode stall
    imem_ack = 1'b0; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lit_stall_addr", {31'd0, imem_req, imem_addr}, 64'h1_0000_0010);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("lit_hold_instr", {31'd0, instr_valid, instr}, 64'h1_0000_0004);
      check("lit_hold_count", {48'd0, fetch_count}, 64'd4);
      @(negedge clk);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("lit_hold_count_once", {48'd0, fetch_count}, 64'd5);

    // branch raised outside a consume is ignored, then taken on a consume
    branch_en = 1'b1; branch_target = 32'h0000_0103; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("lit_br_ignored", {32'd0, pc}, 64'h14);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; branch_en = 1'b0;
    check("lit_br_addr", {31'd0, imem_req, imem_addr}, 64'h1_0000_0100);

    // halt, with a simultaneous branch that must be ignored
    use_table = 1'b0; rnd_rdata = {6'h3F, 26'h123}; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    check("lit_halt_op", {58'd0, op}, 64'h3F);
    instr_ready = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_0800;
    @(negedge clk);
    branch_en = 1'b0; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("lit_halted", {62'd0, halted, imem_req}, 64'h2);
      check("lit_halt_pc", {32'd0, pc}, 64'h100);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    check("lit_restart", {30'd0, halted, imem_req, imem_addr}, 64'h1_0000_0000);

    // reset arriving in the hold state together with an ack
    use_table = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    check("lit_mid_valid", {63'd0, instr_valid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_ack = 1'b0;
    check("lit_mid_clear", {15'd0, instr_valid, instr, fetch_count}, 64'd0);
    @(negedge clk);
    check("lit_mid_req", {31'd0, imem_req, imem_addr}, 64'h1_0000_0000);

    // randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      imem_ack      = ($urandom_range(0, 2) != 0);
      instr_ready   = ($urandom_range(0, 2) != 0);
      branch_en     = ($urandom_range(0, 3) == 0);
      branch_target = $urandom;
      use_table     = 1'b0;
      rnd_rdata     = ($urandom_range(0, 39) == 0) ? {6'h3F, 26'($urandom)} : $urandom;
      if (rnd_rdata[31:26] == 6'h3F && $urandom_range(0, 9) != 0) rnd_rdata[31] = 1'b0;
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer that produces the opcode stream consumed by the control-unit decoder. It holds the program counter and issues requests to instruction memory through a req/ack handshake. It latches each returned word into an instruction register and presents it to the datapath with a valid/ready handshake. It sits between instruction memory and the decode stage and drives the 6-bit `op` field the decoder reads.

## Interface

Parameters:
- `ADDR_W`, 32, width of PC and memory address
- `INSTR_W`, 32, instruction width; `op` = `instr[INSTR_W-1 -: 6]`
- `PC_STEP`, 4, byte increment per sequential fetch
- `RESET_PC`, 0, PC value loaded on reset
- `HALT_OP`, 6'b111111, opcode that stops fetching after it is consumed

Ports:
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request, held until acknowledged
- `imem_addr`  out  ADDR_W  fetch address, equal to `pc`
- `imem_ack`  in  1  memory returns `imem_rdata` in this cycle
- `imem_rdata`  in  INSTR_W  instruction word
- `instr`  out  INSTR_W  instruction register
- `op`  out  6  opcode field of `instr`, fed to the decoder
- `instr_valid`  out  1  `instr` holds an unconsumed instruction
- `instr_ready`  in  1  datapath consumes `instr` when high with `instr_valid`
- `branch_en`  in  1  redirect request, sampled only on a consume cycle
- `branch_target`  in  ADDR_W  redirect address
- `pc`  out  ADDR_W  address of the current or pending fetch
- `halted`  out  1  HALT_OP has been consumed and fetching is stopped
- `fetch_count`  out  16  consumed-instruction counter, saturating at 16'hFFFF

## Operation

States: S_REQ, S_HOLD, S_HALT.

- **Reset (`rst`=1 at an edge):**
  - state becomes S_REQ and `pc` becomes RESET_PC.
  - `instr`, `instr_valid`, `halted` and `fetch_count` are cleared to 0.
  - `imem_ack` is ignored during any reset cycle, including reset arriving mid-operation.
- **S_REQ:**
  - `imem_req`=1 and `imem_addr`=`pc`.
  - When `imem_ack`=1, capture `imem_rdata` into `instr`, set `instr_valid`=1 and go to S_HOLD.
  - If no ack arrives, stay in S_REQ with the address held stable.
- **S_HOLD:**
  - `imem_req`=0; `instr` and `op` are held stable.
  - On `instr_valid & instr_ready` (consume):
    - `instr_valid` is cleared.
    - `fetch_count` increments unless it is already saturated.
    - If `op`==HALT_OP, go to S_HALT and set `halted`=1.
    - Otherwise `pc` ← `branch_en` ? `branch_target` with the low log2(PC_STEP) bits zeroed : `pc`+PC_STEP, and go to S_REQ.
- **S_HALT:**
  - No requests are issued, `instr_valid`=0 and `halted`=1.
  - Only `rst` exits this state.
- **Ignored inputs:**
  - `imem_ack` outside S_REQ.
  - `branch_en` outside a consume cycle.
  - `instr_ready` when `instr_valid`=0.
- **PC arithmetic:** modulo 2^ADDR_W, so `pc`+PC_STEP wraps silently from the top of the address space to 0.
- **Branch vs halt:** if the consumed `op` is HALT_OP, a simultaneous `branch_en` is ignored.

## Timing

- All outputs are registered, except `imem_req` and `imem_addr`, which decode combinationally from state and the `pc` register.
- **First request:** `imem_req`=1 in the first cycle after `rst` falls.
- **Ack to valid:** an ack in cycle N gives `instr_valid`=1 in cycle N+1.
- **Consume to next request:** a consume in cycle M gives `imem_req`=1 with the new `pc` in cycle M+1.
- **Peak throughput:** one instruction every 2 cycles, with ack on the request cycle and ready held high.
- **Handshake rules:**
  - `instr` must not change while `instr_valid`=1.
  - `imem_addr` must not change while `imem_req`=1 and no ack has arrived.

## Structure

- **Shared package:**
  - state enum (S_REQ, S_HOLD, S_HALT)
  - HALT_OP and the R-type opcode 6'b000000, shared with the control unit
  - opcode field position constants
- **Sub-module `pc_register`:**
  - holds `pc` with reset load, sequential increment and branch load.
  - interface: `clk`, `rst`, `load_seq`, `load_br`, `target`, `pc`.
- The top level contains the FSM, the instruction register and `fetch_count`.

## Test plan

- **Reset and first fetch:** RESET_PC=0, memory acks every request and returns word k = {6'b000000, 26'dk}, `instr_ready`=1 → `imem_addr` sequence 0, 4, 8, 12, with `instr_valid` every other cycle and `op`=0.
- **Stalls on both sides:** ack delayed 3 cycles, then `instr_ready` held low 5 cycles → `imem_addr` stable over the 3 wait cycles, `instr` stable over the 5 hold cycles, and `fetch_count` increments exactly once.
- **Branch:** `branch_en`=1 with `branch_target`=32'h0000_0103 on a consume → next `imem_addr`=32'h0000_0100. The same `branch_en` pulse asserted outside a consume has no effect.
- **Halt:** fetch a word with `op`=6'b111111 and consume it → `halted`=1 and no further `imem_req`. A later `rst` pulse → fetch restarts at RESET_PC with `halted`=0.
- **Wrap:** RESET_PC=32'hFFFF_FFFC, consume once → next `imem_addr`=0.
- **Reset mid-operation:** `rst` asserted in S_HOLD together with `imem_ack`=1 → the next cycle shows `instr_valid`=0, `instr`=0, `fetch_count`=0, and a request to RESET_PC one cycle after `rst` falls.
